// File: rtl/btb_upd_pkg.sv
// Shared definitions for the BTB update scheduler: request width, payload field
// offsets, flag bit positions, default EX FIFO depth and the grant encoding.
// Ports: none (package).
package btb_upd_pkg;

  localparam int REQ_W          = 77;
  localparam int DEF_FIFO_DEPTH = 4;

  // Payload layout: {pc, index, flags, right_target}
  localparam int PC_LSB    = 45;
  localparam int PC_W      = 32;
  localparam int IDX_LSB   = 40;
  localparam int IDX_W     = 5;
  localparam int FLAGS_LSB = 32;
  localparam int FLAGS_W   = 8;
  localparam int TGT_LSB   = 0;
  localparam int TGT_W     = 32;

  // Bit positions inside the 8-bit flags field
  localparam int FLAG_POP_RAS      = 7;
  localparam int FLAG_PUSH_RAS     = 6;
  localparam int FLAG_ADD_ENTRY    = 5;
  localparam int FLAG_DELETE_ENTRY = 4;
  localparam int FLAG_PRE_ERROR    = 3;
  localparam int FLAG_PRE_RIGHT    = 2;
  localparam int FLAG_TARGET_ERROR = 1;
  localparam int FLAG_RIGHT_ORIEN  = 0;

  typedef enum logic {
    GNT_ID = 1'b0,
    GNT_EX = 1'b1
  } grant_e;

  function automatic logic [PC_W-1:0] req_pc(input logic [REQ_W-1:0] req);
    return req[PC_LSB +: PC_W];
  endfunction

  function automatic logic [IDX_W-1:0] req_index(input logic [REQ_W-1:0] req);
    return req[IDX_LSB +: IDX_W];
  endfunction

endpackage

// File: rtl/btb_update_sched_if.sv
// Handshake bundle between the ID/EX update sources, the scheduler and the BTB
// operate port. master = request sources / BTB side, slave = the scheduler.
// Signals: id_valid/id_ready/id_req/id_flush, ex_valid/ex_ready/ex_req, btb_op_en/btb_op.
interface btb_update_sched_if #(
  parameter int REQ_W = btb_upd_pkg::REQ_W
);
  logic             id_valid;
  logic             id_ready;
  logic [REQ_W-1:0] id_req;
  logic             id_flush;
  logic             ex_valid;
  logic             ex_ready;
  logic [REQ_W-1:0] ex_req;
  logic             btb_op_en;
  logic [REQ_W-1:0] btb_op;

  modport master (
    output id_valid, id_req, id_flush, ex_valid, ex_req,
    input  id_ready, ex_ready, btb_op_en, btb_op
  );

  modport slave (
    input  id_valid, id_req, id_flush, ex_valid, ex_req,
    output id_ready, ex_ready, btb_op_en, btb_op
  );
endinterface

// File: rtl/btb_upd_fifo.sv
// Synchronous FIFO holding EX-side update requests; head is visible on pop_data.
// Ports: clk, reset (sync, active-high), push/push_data, pop/pop_data, full, empty, count.
// Pushes while full and pops while empty are ignored; DEPTH must be a power of two.
module btb_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 77
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/btb_update_sched.sv
// Arbitrates BTB update requests from the unbuffered ID stage and the FIFO-buffered
// EX stage onto a single registered BTB operate port (one grant per cycle).
// Ports: clk, reset (sync, active-high), bus (btb_update_sched_if.slave);
// optional stat_issued/stat_ex_stall when BTB_UPD_STATS_EN is defined.
module btb_update_sched #(
  parameter int FIFO_DEPTH = btb_upd_pkg::DEF_FIFO_DEPTH,  // power of two, >= 2
  parameter int REQ_W      = btb_upd_pkg::REQ_W
) (
  input  logic                clk,
  input  logic                reset,
  btb_update_sched_if.slave   bus
`ifdef BTB_UPD_STATS_EN
  ,
  output logic [31:0]         stat_issued,
  output logic [31:0]         stat_ex_stall
`endif
);
  import btb_upd_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [REQ_W-1:0] ex_head;

  grant_e last_grant;
  grant_e last_grant_nxt;
  logic   gnt_id;
  logic   gnt_ex;
  logic   id_elig;
  logic   ex_elig;

  btb_upd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (REQ_W)
  ) u_ex_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.ex_valid),
    .push_data (bus.ex_req),
    .pop       (gnt_ex),
    .pop_data  (ex_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign id_elig = bus.id_valid && !bus.id_flush;
  assign ex_elig = !fifo_empty;

  // Grant selection. A full FIFO overrides round-robin so EX cannot be starved
  // into back-pressuring execute indefinitely. No grant while reset is applied.
  always_comb begin
    gnt_id         = 1'b0;
    gnt_ex         = 1'b0;
    last_grant_nxt = last_grant;
    if (!reset) begin
      if (id_elig && ex_elig) begin
        if (fifo_count == CNT_W'(FIFO_DEPTH)) gnt_ex = 1'b1;
        else if (last_grant == GNT_EX)       gnt_id = 1'b1;
        else                                 gnt_ex = 1'b1;
      end else begin
        gnt_id = id_elig;
        gnt_ex = ex_elig;
      end
    end
    if (gnt_id)      last_grant_nxt = GNT_ID;
    else if (gnt_ex) last_grant_nxt = GNT_EX;
  end

  // Reset to EX so ID wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) last_grant <= GNT_EX;
    else       last_grant <= last_grant_nxt;
  end

  assign bus.id_ready = gnt_id;
  assign bus.ex_ready = !fifo_full;

  // btb_op keeps its last payload on idle cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.btb_op_en <= 1'b0;
      bus.btb_op    <= '0;
    end else begin
      bus.btb_op_en <= gnt_id || gnt_ex;
      if (gnt_id)      bus.btb_op <= bus.id_req;
      else if (gnt_ex) bus.btb_op <= ex_head;
    end
  end

`ifdef BTB_UPD_STATS_EN
  // stat_issued advances together with btb_op_en, so it always equals the
  // number of strobes driven so far.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_issued   <= '0;
      stat_ex_stall <= '0;
    end else begin
      if ((gnt_id || gnt_ex) && (stat_issued != 32'hFFFF_FFFF))
        stat_issued <= stat_issued + 32'd1;
      if (bus.ex_valid && !bus.ex_ready && (stat_ex_stall != 32'hFFFF_FFFF))
        stat_ex_stall <= stat_ex_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_btb_update_sched.sv
// Bench for btb_update_sched: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations. Stats checks compile in
// only when BTB_UPD_STATS_EN is defined.
module tb_btb_update_sched;
  import btb_upd_pkg::*;

  localparam int DEPTH = 4;

  logic clk;
  logic reset;
`ifdef BTB_UPD_STATS_EN
  logic [31:0] stat_issued;
  logic [31:0] stat_ex_stall;
`endif

  btb_update_sched_if #(.REQ_W(REQ_W)) bus();

  btb_update_sched #(
    .FIFO_DEPTH (DEPTH),
    .REQ_W      (REQ_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef BTB_UPD_STATS_EN
    ,
    .stat_issued   (stat_issued),
    .stat_ex_stall (stat_ex_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [REQ_W-1:0] mq[$];
  bit               m_valid = 1'b0;
  bit               m_last_ex;
  logic             m_en;
  logic [REQ_W-1:0] m_op;
  logic [31:0]      m_issued;
  logic [31:0]      m_stall;

  // Observations from the most recent cycle window
  logic             obs_idr, obs_exr, obs_en;
  logic [REQ_W-1:0] obs_op;

  task automatic chk(input string name, input logic [REQ_W-1:0] act, input logic [REQ_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // 0 = no grant, 1 = ID, 2 = EX
  function automatic int decide(input bit rst, input bit idv, input bit idf);
    bit id_e, ex_e;
    if (rst) return 0;
    id_e = idv && !idf;
    ex_e = mq.size() > 0;
    if (id_e && ex_e) begin
      if (mq.size() == DEPTH) return 2;
      return m_last_ex ? 1 : 2;
    end
    if (id_e) return 1;
    if (ex_e) return 2;
    return 0;
  endfunction

  task automatic model_step(input bit rst, input bit idv, input bit idf, input bit exv,
                            input logic [REQ_W-1:0] idr, input logic [REQ_W-1:0] exr);
    int  g;
    bit  full;
    if (rst) begin
      mq.delete();
      m_last_ex = 1'b1;
      m_en      = 1'b0;
      m_op      = '0;
      m_issued  = '0;
      m_stall   = '0;
      m_valid   = 1'b1;
      return;
    end
    full = (mq.size() == DEPTH);
    g    = decide(1'b0, idv, idf);
    if (exv && full && m_stall != 32'hFFFF_FFFF) m_stall++;
    m_en = (g != 0);
    if (g == 1) begin
      m_op = idr;
      m_last_ex = 1'b0;
    end else if (g == 2) begin
      m_op = mq.pop_front();
      m_last_ex = 1'b1;
    end
    if (g != 0 && m_issued != 32'hFFFF_FFFF) m_issued++;
    if (exv && !full) mq.push_back(exr);
  endtask

  // One clock: drive at negedge, compare against the model, advance at posedge.
  task automatic cycle(input bit rst, input bit idv, input bit idf, input logic [REQ_W-1:0] idr,
                       input bit exv, input logic [REQ_W-1:0] exr);
    int g;
    @(negedge clk);
    reset        = rst;
    bus.id_valid = idv;
    bus.id_flush = idf;
    bus.id_req   = idr;
    bus.ex_valid = exv;
    bus.ex_req   = exr;
    #1;
    obs_idr = bus.id_ready;
    obs_exr = bus.ex_ready;
    obs_en  = bus.btb_op_en;
    obs_op  = bus.btb_op;
    if (m_valid) begin
      g = decide(rst, idv, idf);
      chk("id_ready", REQ_W'(obs_idr), REQ_W'(g == 1));
      chk("ex_ready", REQ_W'(obs_exr), REQ_W'(mq.size() < DEPTH));
      chk("btb_op_en", REQ_W'(obs_en), REQ_W'(m_en));
      chk("btb_op", obs_op, m_op);
`ifdef BTB_UPD_STATS_EN
      chk("stat_issued", REQ_W'(stat_issued), REQ_W'(m_issued));
      chk("stat_ex_stall", REQ_W'(stat_ex_stall), REQ_W'(m_stall));
`endif
    end
    @(posedge clk);
    model_step(rst, idv, idf, exv, idr, exr);
  endtask

  function automatic logic [REQ_W-1:0] rnd_req();
    logic [REQ_W-1:0] r;
    r[31:0]  = $urandom();
    r[63:32] = $urandom();
    r[76:64] = 13'($urandom());
    return r;
  endfunction

  function automatic logic [REQ_W-1:0] mk_req(input logic [31:0] pc, input logic [4:0] idx);
    logic [REQ_W-1:0] r;
    r = rnd_req();
    r[PC_LSB +: PC_W]   = pc;
    r[IDX_LSB +: IDX_W] = idx;
    return r;
  endfunction

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    logic [DEPTH*3-1:0] dummy;
    bit   idr_log[1:10];
    bit   exr_log[1:10];
    int   exv_pct;

    reset        = 1'b1;
    bus.id_valid = 1'b0;
    bus.id_flush = 1'b0;
    bus.id_req   = '0;
    bus.ex_valid = 1'b0;
    bus.ex_req   = '0;
    dummy        = '0;

    do_reset();
    do_reset();

    // Reset state with idle inputs
    idle();
    chk("rst_id_ready", REQ_W'(obs_idr), REQ_W'(0));
    chk("rst_ex_ready", REQ_W'(obs_exr), REQ_W'(1));
    chk("rst_btb_op_en", REQ_W'(obs_en), REQ_W'(0));
    chk("rst_btb_op", obs_op, '0);

    // ID only: accepted same cycle, strobe next cycle
    cycle(1'b0, 1'b1, 1'b0, mk_req(32'h1C00_0010, 5'd1), 1'b0, '0);
    chk("id_only_ready", REQ_W'(obs_idr), REQ_W'(1));
    idle();
    chk("id_only_en", REQ_W'(obs_en), REQ_W'(1));
    chk("id_only_pc", REQ_W'(req_pc(obs_op)), REQ_W'(32'h1C00_0010));

    // Flushed ID with empty FIFO: no acceptance, no strobe
    do_reset();
    cycle(1'b0, 1'b1, 1'b1, mk_req(32'h2000_0000, 5'd2), 1'b0, '0);
    chk("flush_id_ready", REQ_W'(obs_idr), REQ_W'(0));
    idle();
    chk("flush_en", REQ_W'(obs_en), REQ_W'(0));

    // Both sources continuously valid: alternate from ID until the FIFO fills,
    // then EX wins while full and ID is granted again once below full.
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      cycle(1'b0, 1'b1, 1'b0, mk_req(32'h3000_0000 + k, 5'(k)),
            1'b1, mk_req(32'h4000_0000 + k, 5'(k + 16)));
      idr_log[k] = obs_idr;
      exr_log[k] = obs_exr;
    end
    chk("alt_c1_id", REQ_W'(idr_log[1]), REQ_W'(1));
    chk("alt_c2_ex", REQ_W'(idr_log[2]), REQ_W'(0));
    chk("alt_c3_id", REQ_W'(idr_log[3]), REQ_W'(1));
    chk("alt_c4_ex", REQ_W'(idr_log[4]), REQ_W'(0));
    chk("full_ex_ready", REQ_W'(exr_log[8]), REQ_W'(0));
    chk("full_ex_wins", REQ_W'(idr_log[8]), REQ_W'(0));
    chk("below_full_id", REQ_W'(idr_log[9]), REQ_W'(1));
    chk("refull_ex_ready", REQ_W'(exr_log[10]), REQ_W'(0));
    idle();
`ifdef BTB_UPD_STATS_EN
    chk("stats_issued_10", REQ_W'(stat_issued), REQ_W'(10));
    chk("stats_stall_2", REQ_W'(stat_ex_stall), REQ_W'(2));
`endif
    for (int k = 0; k < 5; k++) idle();

    // Reset discards queued EX requests after the first issue
    do_reset();
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, mk_req(32'h5000_0000, 5'd3));
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, mk_req(32'h5000_0004, 5'd7));
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, mk_req(32'h5000_0008, 5'd9));
    chk("first_issue_en", REQ_W'(obs_en), REQ_W'(1));
    chk("first_issue_idx", REQ_W'(req_index(obs_op)), REQ_W'(3));
    for (int k = 0; k < 3; k++) begin
      idle();
      chk("post_rst_no_strobe", REQ_W'(obs_en), REQ_W'(0));
      chk("post_rst_ex_ready", REQ_W'(obs_exr), REQ_W'(1));
    end

    // Randomized traffic in phases of varying EX pressure
    for (int ph = 0; ph < 4; ph++) begin
      exv_pct = (ph == 0) ? 30 : (ph == 1) ? 90 : (ph == 2) ? 60 : 100;
      for (int k = 0; k < 600; k++) begin
        cycle(($urandom_range(0, 199) == 0),
              ($urandom_range(0, 99) < 70),
              ($urandom_range(0, 99) < 20),
              rnd_req(),
              ($urandom_range(0, 99) < exv_pct),
              rnd_req());
      end
    end
    for (int k = 0; k < 8; k++) idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
